// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// Optional overflow detection is selected with SIGNED_DIVIDER_OVF_DETECT_EN.
package divider_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned CNT_W = cnt_w(DEF_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/signed_divider_div_step.sv
// One combinational radix-2 restoring iteration on magnitudes.
// Shifts in one dividend bit, trial-subtracts the divisor, restores on borrow.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shf;
    logic [WIDTH:0] diff;
    logic           unused_msb;

    // The partial remainder stays below |divisor| <= 2^(W-1), so its MSB is spare.
    assign unused_msb = rem_i[WIDTH];
    assign shf        = {rem_i[WIDTH-1:0], bit_i};
    assign diff       = shf - {1'b0, dvs_i};
    assign q_o        = ~diff[WIDTH];
    assign rem_o      = q_o ? diff : shf;

endmodule

// File: rtl/signed_divider.sv
// Sequential 2W/W signed divider, one quotient bit per cycle, start/busy/done.
// Define SIGNED_DIVIDER_OVF_DETECT_EN to enable quotient overflow detection.
module signed_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] QMAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] QMAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sd_q, sd_d;
    logic               sv_q, sv_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [2*WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic               neg_q;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Two's-complement negation leaves the most-negative pattern unchanged.
    assign dvd_mag = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
    assign dvs_mag = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
    assign neg_q   = sd_q ^ sv_q;
    assign q_fix   = neg_q ? -quo_q : quo_q;
    assign r_fix   = sd_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
    logic ovf_q, ovf_d;
    logic post_ovf;

    assign post_ovf = neg_q ? (quo_q > QMAX_NEG) : (quo_q > QMAX_POS);
    assign overflow = ovf_q;
`else
    logic unused_lim;

    assign unused_lim = |(QMAX_POS & QMAX_NEG);
    assign overflow   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        sd_d        = sd_q;
        sv_d        = sv_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sd_d    = dividend[2*WIDTH-1];
                    sv_d    = divisor[WIDTH-1];
                    state_d = PREP;
                end
            end
            PREP: begin
                dvd_d   = dvd_mag;
                dvs_d   = dvs_mag;
                rem_d   = {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
                quo_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = DIV;
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q[WIDTH-1:0];
                    dbz_d       = 1'b1;
`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
                    ovf_d       = 1'b0;
`endif
                    state_d     = DONE;
                end
`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
                else if (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                dvd_d = {dvd_q[2*WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                dbz_d       = 1'b0;
`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
                ovf_d       = post_ovf;
                if (post_ovf) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                end
`endif
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            sd_q        <= sd_d;
            sv_q        <= sv_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    assign busy        = (state_q == PREP) || (state_q == DIV) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_divider.sv
// Randomised and directed bench for signed_divider against an arithmetic model.
// Honours SIGNED_DIVIDER_OVF_DETECT_EN when building expectations.
module tb_signed_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dbz;
        bit           ovf;
        bit           chk;
        int           lat;
        int           acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t expq[$];
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    bit   known = 1'b1;

    signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Result defined from sign rules and unsigned magnitude division.
    function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        logic [63:0] md, mv, qm, rm, lim;
        bit neg, big;
        e.acc = 0;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.chk = 1'b1;
        e.lat = W + 2;
        if (dvs == '0) begin
            e.q = '1;
            e.r = dvd[W-1:0];
            e.dbz = 1'b1;
            e.lat = 1;
            return e;
        end
        md  = dvd[2*W-1] ? -dvd : dvd;
        mv  = {32'd0, dvs[W-1] ? -dvs : dvs};
        qm  = md / mv;
        rm  = md % mv;
        neg = dvd[2*W-1] ^ dvs[W-1];
        lim = neg ? 64'h8000_0000 : 64'h7FFF_FFFF;
        big = qm > lim;
        e.q = neg ? -qm[W-1:0] : qm[W-1:0];
        e.r = dvd[2*W-1] ? -rm[W-1:0] : rm[W-1:0];
`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
        if (big) begin
            e.ovf = 1'b1;
            e.q = '0;
            e.r = '0;
            if (md[63:32] >= mv) e.lat = 1;
        end
`else
        if (big) e.chk = 1'b0;
`endif
        return e;
    endfunction

    task automatic pin(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input bit dbz, input bit ovf, input bit chkv, input int lat);
        exp_t e;
        e = model(dvd, dvs);
        chk("pin_ovf", 64'(e.ovf), 64'(ovf));
        chk("pin_dbz", 64'(e.dbz), 64'(dbz));
        chk("pin_lat", 64'(e.lat), 64'(lat));
        chk("pin_chk", 64'(e.chk), 64'(chkv));
        if (chkv) begin
            chk("pin_q", 64'(e.q), 64'(q));
            chk("pin_r", 64'(e.r), 64'(r));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (expq.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("dbz", 64'(div_by_zero), 64'(e.dbz));
                    chk("ovf", 64'(overflow), 64'(e.ovf));
                    chk("busy_in_done", 64'(busy), 64'd0);
                    if (e.chk) begin
                        chk("quotient", 64'(quotient), 64'(e.q));
                        chk("remainder", 64'(remainder), 64'(e.r));
                    end
                    hold_q = quotient;
                    hold_r = remainder;
                    known  = e.chk;
                end
            end else if (known) begin
                if (quotient !== hold_q) chk("hold_q", 64'(quotient), 64'(hold_q));
                if (remainder !== hold_r) chk("hold_r", 64'(remainder), 64'(hold_r));
            end
        end
    end

    // Caller guarantees the DUT is idle or showing done.
    task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e = model(dvd, dvs);
        e.acc = cyc;
        expq.push_back(e);
        start = 1'b0;
        dividend = $urandom();
        divisor = $urandom();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            chk("timeout", 64'(expq.size()), 64'd0);
            expq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        @(negedge clk);
        issue(dvd, dvs);
        wait_done();
    endtask

    initial begin
        logic [63:0] x;
        logic [31:0] y;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        pin(64'd100, 32'd7, 32'd14, 32'd2, 0, 0, 1, 34);
        pin(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0, 1, 34);
        pin(64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 0, 0, 1, 34);
        pin(64'h4000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 0, 0, 1, 34);
        pin(64'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 0, 1, 1);
`ifdef SIGNED_DIVIDER_OVF_DETECT_EN
        pin(64'h0000_0001_0000_0000, 32'd1, 32'd0, 32'd0, 0, 1, 1, 1);
`else
        pin(64'h0000_0001_0000_0000, 32'd1, 32'd0, 32'd0, 0, 0, 0, 34);
`endif

        run(64'd100, 32'd7);
        run(64'hFFFF_FFFF_FFFF_FF9C, 32'd7);
        run(64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF);
        run(64'h4000_0000_0000_0000, 32'h8000_0000);
        run(64'h1234, 32'd0);
        run(64'h0000_0001_0000_0000, 32'd1);
        run(64'h8000_0000_0000_0000, 32'h8000_0000);
        run(-64'sd7, -32'sd2);

        // Back-to-back: next start lands in the done cycle.
        @(negedge clk);
        issue(64'd1000, 32'd9);
        n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        issue(-64'sd1000, 32'd9);
        wait_done();

        // Start while busy must be ignored.
        @(negedge clk);
        issue(64'd12345, 32'd100);
        repeat (5) @(negedge clk);
        dividend = 64'd999;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done();

        // Reset in the middle of an operation.
        @(negedge clk);
        issue(-64'sd100, 32'd7);
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expq.delete();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_q", 64'(quotient), 64'd0);
        chk("mid_rst_r", 64'(remainder), 64'd0);
        chk("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        hold_q = '0;
        hold_r = '0;
        known  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(64'd100, 32'd7);

        for (int i = 0; i < 60; i++) begin
            x = {$urandom(), $urandom()};
            x = $signed(x) >>> $urandom_range(0, 63);
            y = $urandom();
            y = $signed(y) >>> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) y = '0;
            run(x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
